multichannel_direct_digital_synthesizer: RTL and testbench

//  Parametrised N-channel DDS: per-channel phase accumulator, phase offset, amplitude scaling.

---
 rtl/multichannel_direct_digital_synthesizer.sv | 131 +++++++++++++
 tb/tb_multichannel_direct_digital_synthesizer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_direct_digital_synthesizer.sv
// N-channel DDS: phase accumulate + offset, quarter-wave sine LUT, amplitude scale; 4 cycles acc -> io_B.
// No backpressure: a sample is produced every cycle, qualified by io_valid (io_enable delayed 4 cycles).
module multichannel_direct_digital_synthesizer #(
    parameter int g_channels = 2,
    parameter int g_accWidth = 32,
    parameter int g_lutBits  = 10,
    parameter int g_outWidth = 12
) (
    input  logic                                                    clock,
    input  logic                                                    reset,
    input  logic                                                    io_enable,
    input  logic                                                    io_sync,
    input  logic                                                    io_update,
    input  logic                                                    io_cfg_wen,
    input  logic [((g_channels > 1) ? $clog2(g_channels) : 1)-1:0] io_cfg_chan,
    input  logic [1:0]                                              io_cfg_sel,
    input  logic [g_accWidth-1:0]                                   io_cfg_data,
    output logic [g_channels*g_outWidth-1:0]                        io_B,
    output logic                                                    io_valid
);

    localparam int ChanW   = (g_channels > 1) ? $clog2(g_channels) : 1;
    localparam int AddrW   = g_lutBits - 2;
    localparam int Quarter = 1 << AddrW;
    localparam int ProdW   = 2 * g_outWidth;
    localparam logic [g_outWidth-1:0] AmpUnity = {1'b1, {(g_outWidth-1){1'b0}}};

    // Half-step sampling keeps every entry nonzero and makes the quarter mirror exact.
    function automatic logic signed [g_outWidth-1:0] rom_entry(input int k);
        real peak;
        real v;
        peak = real'((1 << (g_outWidth - 1)) - 1);
        v    = peak * $sin(2.0 * 3.141592653589793 * (real'(k) + 0.5) / real'(1 << g_lutBits));
        return g_outWidth'($rtoi(v + 0.5));
    endfunction

    logic signed [g_outWidth-1:0] rom [Quarter];

    for (genvar k = 0; k < Quarter; k++) begin : g_rom
        localparam logic signed [g_outWidth-1:0] RomVal = rom_entry(k);
        assign rom[k] = RomVal;
    end

    logic [g_accWidth-1:0]        acc     [g_channels];
    logic [g_accWidth-1:0]        ftw_sh  [g_channels];
    logic [g_accWidth-1:0]        ftw_act [g_channels];
    logic [g_accWidth-1:0]        off_sh  [g_channels];
    logic [g_accWidth-1:0]        off_act [g_channels];
    logic [g_outWidth-1:0]        amp_sh  [g_channels];
    logic [g_outWidth-1:0]        amp_act [g_channels];
    logic [g_outWidth-1:0]        amp_eff [g_channels];
    logic [g_lutBits-1:0]         p_r     [g_channels];
    logic [g_channels-1:0]        q1_r;
    logic [AddrW-1:0]             addr_r  [g_channels];
    logic signed [g_outWidth-1:0] s_r     [g_channels];
    logic signed [g_outWidth-1:0] b_r     [g_channels];
    logic signed [ProdW-1:0]      prod    [g_channels];
    logic [3:0]                   vld_sr;

    // Shadow writes and the commit share an edge; active takes the pre-write shadow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < g_channels; k++) begin
                ftw_sh[k]  <= '0;
                ftw_act[k] <= '0;
                off_sh[k]  <= '0;
                off_act[k] <= '0;
                amp_sh[k]  <= AmpUnity;
                amp_act[k] <= AmpUnity;
            end
        end else begin
            for (int k = 0; k < g_channels; k++) begin
                if (io_update) begin
                    ftw_act[k] <= ftw_sh[k];
                    off_act[k] <= off_sh[k];
                    amp_act[k] <= amp_sh[k];
                end
                if (io_cfg_wen && io_cfg_chan == ChanW'(k)) begin
                    case (io_cfg_sel)
                        2'd0:    ftw_sh[k] <= io_cfg_data;
                        2'd1:    off_sh[k] <= io_cfg_data;
                        2'd2:    amp_sh[k] <= io_cfg_data[g_outWidth-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < g_channels; k++) begin
            amp_eff[k] = (amp_act[k] > AmpUnity) ? AmpUnity : amp_act[k];
            prod[k]    = ProdW'(s_r[k]) * ProdW'($signed({1'b0, amp_eff[k]}));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < g_channels; k++) begin
                acc[k]    <= '0;
                p_r[k]    <= '0;
                addr_r[k] <= '0;
                s_r[k]    <= '0;
                b_r[k]    <= '0;
            end
            q1_r   <= '0;
            vld_sr <= '0;
        end else begin
            for (int k = 0; k < g_channels; k++) begin
                if (io_sync) begin
                    acc[k] <= '0;
                end else if (io_enable) begin
                    acc[k] <= acc[k] + ftw_act[k];
                end
                p_r[k]    <= g_lutBits'((acc[k] + off_act[k]) >> (g_accWidth - g_lutBits));
                q1_r[k]   <= p_r[k][g_lutBits-1];
                addr_r[k] <= p_r[k][AddrW] ? ~p_r[k][AddrW-1:0] : p_r[k][AddrW-1:0];
                s_r[k]    <= q1_r[k] ? -rom[addr_r[k]] : rom[addr_r[k]];
                b_r[k]    <= g_outWidth'(prod[k] >>> (g_outWidth - 1));
            end
            vld_sr <= {vld_sr[2:0], io_enable};
        end
    end

    for (genvar k = 0; k < g_channels; k++) begin : g_out
        assign io_B[k*g_outWidth +: g_outWidth] = b_r[k];
    end

    assign io_valid = vld_sr[3];

endmodule

// File: tb/tb_multichannel_direct_digital_synthesizer.sv
// Self-checking bench: hand-derived vector tables plus a cycle-level behavioural reference model.
module tb_multichannel_direct_digital_synthesizer;

    localparam int  N     = 2;
    localparam int  OW    = 12;
    localparam int  UNITY = 1 << (OW - 1);
    localparam real PI    = 3.141592653589793;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_enable = 1'b0;
    logic          io_sync = 1'b0;
    logic          io_update = 1'b0;
    logic          io_cfg_wen = 1'b0;
    logic [0:0]    io_cfg_chan = '0;
    logic [1:0]    io_cfg_sel = '0;
    logic [31:0]   io_cfg_data = '0;
    logic [N*OW-1:0] io_B;
    logic          io_valid;

    always #5 clock = ~clock;

    multichannel_direct_digital_synthesizer #(
        .g_channels(N), .g_accWidth(32), .g_lutBits(10), .g_outWidth(OW)
    ) dut (
        .clock(clock), .reset(reset), .io_enable(io_enable), .io_sync(io_sync),
        .io_update(io_update), .io_cfg_wen(io_cfg_wen), .io_cfg_chan(io_cfg_chan),
        .io_cfg_sel(io_cfg_sel), .io_cfg_data(io_cfg_data), .io_B(io_B), .io_valid(io_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: configuration, phase, and samples in flight.
    logic [31:0] m_acc [N];
    logic [31:0] m_ftw_sh [N];
    logic [31:0] m_ftw [N];
    logic [31:0] m_off_sh [N];
    logic [31:0] m_off [N];
    int          m_amp_sh [N];
    int          m_amp [N];
    int          m_sq [3][N];
    int          m_b [N];
    int          m_v [4];

    typedef struct {
        int amp;
        int e0;
        int e1;
        int e2;
        int e3;
    } amp_vec_t;

    amp_vec_t vecs [5];
    int unity_seq [4] = '{6, 2047, -6, -2047};

    function automatic int ideal_sample(input logic [31:0] ph);
        int  idx;
        real v;
        idx = int'(ph >> 22);
        v   = real'(UNITY - 1) * $sin(2.0 * PI * (real'(idx) + 0.5) / 1024.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int scale(input int s, input int amp);
        int a;
        int p;
        a = (amp > UNITY) ? UNITY : amp;
        p = s * a;
        if (p >= 0) return p / UNITY;
        return -((-p + UNITY - 1) / UNITY);
    endfunction

    function automatic logic signed [31:0] dut_ch(input int k);
        logic signed [OW-1:0] v;
        v = io_B[k*OW +: OW];
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cleared pipeline holds phase 0 in the two unsigned stages and zero in the signed stage.
    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_acc[k] = '0; m_ftw_sh[k] = '0; m_ftw[k] = '0;
            m_off_sh[k] = '0; m_off[k] = '0;
            m_amp_sh[k] = UNITY; m_amp[k] = UNITY;
            m_sq[0][k] = ideal_sample(32'd0);
            m_sq[1][k] = ideal_sample(32'd0);
            m_sq[2][k] = 0;
            m_b[k] = 0;
        end
        for (int i = 0; i < 4; i++) m_v[i] = 0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            m_b[k]     = scale(m_sq[2][k], m_amp[k]);
            m_sq[2][k] = m_sq[1][k];
            m_sq[1][k] = m_sq[0][k];
            m_sq[0][k] = ideal_sample(m_acc[k] + m_off[k]);
            if (io_sync)        m_acc[k] = '0;
            else if (io_enable) m_acc[k] = m_acc[k] + m_ftw[k];
            if (io_update) begin
                m_ftw[k] = m_ftw_sh[k];
                m_off[k] = m_off_sh[k];
                m_amp[k] = m_amp_sh[k];
            end
            if (io_cfg_wen && int'(io_cfg_chan) == k) begin
                case (io_cfg_sel)
                    2'd0:    m_ftw_sh[k] = io_cfg_data;
                    2'd1:    m_off_sh[k] = io_cfg_data;
                    2'd2:    m_amp_sh[k] = int'(io_cfg_data[OW-1:0]);
                    default: ;
                endcase
            end
        end
        m_v[3] = m_v[2]; m_v[2] = m_v[1]; m_v[1] = m_v[0];
        m_v[0] = int'(io_enable);
    endtask

    task automatic tick();
        if (!reset) model_reset();
        else        model_edge();
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) check($sformatf("model_ch%0d", k), dut_ch(k), m_b[k]);
        check("model_valid", signed'({31'd0, io_valid}), m_v[3]);
    endtask

    task automatic cfg_write(input int chan, input int sel, input logic [31:0] data);
        io_cfg_wen  = 1'b1;
        io_cfg_chan = 1'(chan);
        io_cfg_sel  = 2'(sel);
        io_cfg_data = data;
        tick();
        io_cfg_wen  = 1'b0;
    endtask

    // Enables streaming and checks that io_valid is still low on the third edge.
    task automatic lead_in(input string name);
        io_enable = 1'b1;
        tick(); tick(); tick();
        check(name, signed'({31'd0, io_valid}), 0);
    endtask

    initial begin
        int e [4];

        vecs[0] = '{amp: 1024, e0: 3, e1: 1023, e2: -3, e3: -1024};
        vecs[1] = '{amp: 4095, e0: 6, e1: 2047, e2: -6, e3: -2047};
        vecs[2] = '{amp: 1,    e0: 0, e1: 0,    e2: -1, e3: -1};
        vecs[3] = '{amp: 0,    e0: 0, e1: 0,    e2: 0,  e3: 0};
        vecs[4] = '{amp: 2048, e0: 6, e1: 2047, e2: -6, e3: -2047};

        // Reset takes effect without a clock edge.
        #1 reset = 1'b0;
        #1 model_reset();
        check("rst_ch0", dut_ch(0), 0);
        check("rst_ch1", dut_ch(1), 0);
        check("rst_valid", signed'({31'd0, io_valid}), 0);
        tick(); tick();
        #2 reset = 1'b1;

        // FTW=0: constant phase-0 sample on both channels once valid.
        lead_in("t1_valid_low");
        tick();
        check("t1_valid_high", signed'({31'd0, io_valid}), 1);
        check("t1_ch0", dut_ch(0), 6);
        check("t1_ch1", dut_ch(1), 6);

        // Quarter-rate tone on ch0 under a table of amplitudes.
        io_enable = 1'b0;
        cfg_write(0, 0, 32'h4000_0000);
        for (int v = 0; v < 5; v++) begin
            io_enable = 1'b0;
            cfg_write(0, 2, 32'(vecs[v].amp));
            io_update = 1'b1; tick(); io_update = 1'b0;
            io_sync = 1'b1; tick(); io_sync = 1'b0;
            lead_in($sformatf("amp%0d_valid_low", vecs[v].amp));
            e = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
            for (int i = 0; i < 8; i++) begin
                tick();
                check($sformatf("amp%0d_ch0_s%0d", vecs[v].amp, i), dut_ch(0), e[i % 4]);
                check($sformatf("amp%0d_valid", vecs[v].amp), signed'({31'd0, io_valid}), 1);
            end
        end

        // Half-cycle offset on ch1 gives the negated ch0 waveform.
        io_enable = 1'b0;
        cfg_write(1, 0, 32'h4000_0000);
        cfg_write(1, 1, 32'h8000_0000);
        io_update = 1'b1; io_sync = 1'b1; tick(); io_update = 1'b0; io_sync = 1'b0;
        lead_in("t4_valid_low");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_ch0", dut_ch(0), unity_seq[i % 4]);
            check("t4_ch1_neg", dut_ch(1), -unity_seq[i % 4]);
        end

        // A write on the update edge is not committed until the next update.
        io_cfg_wen = 1'b1; io_cfg_chan = 1'b0; io_cfg_sel = 2'd0; io_cfg_data = 32'h2000_0000;
        io_update = 1'b1; io_sync = 1'b1;
        tick();
        io_cfg_wen = 1'b0; io_update = 1'b0; io_sync = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_rate_kept", dut_ch(0), unity_seq[i]);
        end
        io_update = 1'b1; io_sync = 1'b1; tick(); io_update = 1'b0; io_sync = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t5_period8_s%0d", i), dut_ch(0), scale(ideal_sample(32'(i) << 29), UNITY));
        end

        // Reset pulse between edges clears outputs and configuration immediately.
        cfg_write(0, 2, 32'd1024);
        io_update = 1'b1; tick(); io_update = 1'b0;
        tick(); tick(); tick(); tick();
        #2 reset = 1'b0;
        #1 model_reset();
        check("t6_ch0_cleared", dut_ch(0), 0);
        check("t6_ch1_cleared", dut_ch(1), 0);
        check("t6_valid_cleared", signed'({31'd0, io_valid}), 0);
        #1 reset = 1'b1;
        lead_in("t6_valid_low");
        tick();
        check("t6_valid_high", signed'({31'd0, io_valid}), 1);
        check("t6_ch0_unity", dut_ch(0), 6);
        check("t6_ch1_no_offset", dut_ch(1), 6);

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            io_enable   = ($urandom_range(0, 3) != 0);
            io_sync     = ($urandom_range(0, 31) == 0);
            io_update   = ($urandom_range(0, 7) == 0);
            io_cfg_wen  = ($urandom_range(0, 1) == 1);
            io_cfg_chan = 1'($urandom_range(0, 1));
            io_cfg_sel  = 2'($urandom_range(0, 3));
            io_cfg_data = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4095));
            tick();
        end
        io_enable = 1'b0; io_sync = 1'b0; io_update = 1'b0; io_cfg_wen = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
